// File: rtl/wt32_prod_accumulator_if.sv
// Handshake bundle between the multiplier product stream, the accumulator and its consumer.
interface wt32_prod_accumulator_if #(
   parameter int unsigned PW = 64,
   parameter int unsigned AW = 72,
   parameter int unsigned CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_prod;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_count;
   logic          out_ovf;

   // Accumulator side: consumes products, produces results
   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );

   // Environment side: produces products, consumes results
   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/wt32_prod_accumulator.sv
// Registered dot-product accumulation stage behind the 32x32 multiplier: sums up to LEN
// products per vector and hands the result out over valid/ready.
module wt32_prod_accumulator #(
   parameter int unsigned PW  = 64,
   parameter int unsigned AW  = 72,
   parameter int unsigned LEN = 8,
   parameter int unsigned CW  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   wt32_prod_accumulator_if.slave   bus
);

   typedef enum logic {S_ACC, S_DONE} state_t;

   // Elaboration-time guard on the parameter relationships
   if (AW < PW || (2 ** CW) <= LEN || LEN < 1) begin : g_bad_param
      $error("wt32_prod_accumulator: illegal PW/AW/LEN/CW combination");
   end

   state_t        r_state, w_state;
   logic [AW-1:0] r_acc, w_acc;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [AW-1:0] r_out_sum, w_out_sum;
   logic [CW-1:0] r_out_count, w_out_count;
   logic          r_out_ovf, w_out_ovf;
   logic          r_in_ready, w_in_ready;
   logic          r_out_valid, w_out_valid;

   logic [AW:0]   w_sum;
   logic [CW-1:0] w_cnt_inc;
   logic          w_hs_in;
   logic          w_hs_out;

   assign w_sum     = {1'b0, r_acc} + (AW+1)'(bus.in_prod);
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_hs_in   = bus.in_valid & r_in_ready;
   assign w_hs_out  = r_out_valid & bus.out_ready;

   // Next-state and datapath update; clear overrides any handshake
   always_comb begin
      w_state     = r_state;
      w_acc       = r_acc;
      w_cnt       = r_cnt;
      w_out_sum   = r_out_sum;
      w_out_count = r_out_count;
      w_out_ovf   = r_out_ovf;
      if (clear) begin
         w_state   = S_ACC;
         w_acc     = '0;
         w_cnt     = '0;
         w_out_ovf = 1'b0;
      end else begin
         case (r_state)
            S_ACC: begin
               if (w_hs_in) begin
                  w_acc     = w_sum[AW-1:0];
                  w_out_ovf = r_out_ovf | w_sum[AW];
                  w_cnt     = w_cnt_inc;
                  if (w_cnt_inc == CW'(LEN) || bus.in_last) begin
                     w_out_sum   = w_sum[AW-1:0];
                     w_out_count = w_cnt_inc;
                     w_state     = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (w_hs_out) begin
                  w_acc     = '0;
                  w_cnt     = '0;
                  w_out_ovf = 1'b0;
                  w_state   = S_ACC;
               end
            end
            default: w_state = S_ACC;
         endcase
      end
      w_in_ready  = (w_state == S_ACC);
      w_out_valid = (w_state == S_DONE);
   end

   // State and output registers; in_ready stays low until the first edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_acc       <= w_acc;
         r_cnt       <= w_cnt;
         r_out_sum   <= w_out_sum;
         r_out_count <= w_out_count;
         r_out_ovf   <= w_out_ovf;
         r_in_ready  <= w_in_ready;
         r_out_valid <= w_out_valid;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_count = r_out_count;
   assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_wt32_prod_accumulator.sv
// Bench for wt32_prod_accumulator: reference model of the vector sums plus directed vectors.
module tb_wt32_prod_accumulator;
   localparam int unsigned PW  = 64;
   localparam int unsigned AW  = 72;
   localparam int unsigned LEN = 8;
   localparam int unsigned CW  = 8;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic [AW-1:0] s;
      logic [CW-1:0] c;
      logic          o;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic clear64 = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   res_t rq[$];

   always #5 clk = ~clk;

   wt32_prod_accumulator_if #(.PW(PW), .AW(AW), .CW(CW)) u_if ();
   wt32_prod_accumulator_if #(.PW(64), .AW(64), .CW(8))  u_if64 ();

   wt32_prod_accumulator #(.PW(PW), .AW(AW), .LEN(LEN), .CW(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(u_if));

   wt32_prod_accumulator #(.PW(64), .AW(64), .LEN(2), .CW(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .clear(clear64), .bus(u_if64));

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: exact vector sum, wrapped to AW bits for the result
   logic          m_rdy, m_vld, m_ovf;
   logic [AW-1:0] m_sum;
   logic [CW-1:0] m_cnt;
   logic [127:0]  tsum;
   int            n;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rdy = 0; m_vld = 0; m_ovf = 0; m_sum = '0; m_cnt = '0; tsum = '0; n = 0;
      end else if (clear) begin
         m_vld = 0; m_rdy = 1; m_ovf = 0; tsum = '0; n = 0;
      end else if (m_vld) begin
         if (u_if.out_ready) begin
            m_vld = 0; m_rdy = 1; m_ovf = 0; tsum = '0; n = 0;
         end
      end else if (m_rdy && u_if.in_valid) begin
         tsum  = tsum + 128'(u_if.in_prod);
         n     = n + 1;
         m_ovf = (tsum >> AW) != 0;
         if (n == int'(LEN) || u_if.in_last) begin
            m_vld = 1; m_rdy = 0; m_sum = AW'(tsum); m_cnt = CW'(n);
         end
      end else begin
         m_rdy = 1;
      end
   end

   // Cycle compare against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready",  128'(u_if.in_ready),  128'(m_rdy));
         chk("out_valid", 128'(u_if.out_valid), 128'(m_vld));
         chk("out_sum",   128'(u_if.out_sum),   128'(m_sum));
         chk("out_count", 128'(u_if.out_count), 128'(m_cnt));
         chk("out_ovf",   128'(u_if.out_ovf),   128'(m_ovf));
      end
   end

   // Capture accepted results for literal checks
   always @(negedge clk) begin
      if (rst_n && u_if.out_valid && u_if.out_ready)
         rq.push_back('{s: u_if.out_sum, c: u_if.out_count, o: u_if.out_ovf});
   end

   task automatic send(input logic [63:0] p, input logic last);
      int t = 0;
      u_if.in_valid = 1'b1;
      u_if.in_prod  = p;
      u_if.in_last  = last;
      while (!u_if.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!u_if.in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
      @(negedge clk);
      u_if.in_valid = 1'b0;
      u_if.in_last  = 1'b0;
   endtask

   task automatic check_res(input string nm, input logic [AW-1:0] s, input logic [CW-1:0] c,
                            input logic o);
      res_t r;
      int   t = 0;
      while (rq.size() == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (rq.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: no result seen, required one", nm);
      end else begin
         r = rq.pop_front();
         chk({nm, "_sum"},   128'(r.s), 128'(s));
         chk({nm, "_count"}, 128'(r.c), 128'(c));
         chk({nm, "_ovf"},   128'(r.o), 128'(o));
      end
   endtask

   initial begin
      logic [31:0] a, b;
      logic [63:0] p;
      u_if.in_valid = 0; u_if.in_prod = '0; u_if.in_last = 0; u_if.out_ready = 1;
      u_if64.in_valid = 0; u_if64.in_prod = '0; u_if64.in_last = 0; u_if64.out_ready = 0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 128'(u_if.out_valid), 128'(0));
      chk("rst_in_ready",  128'(u_if.in_ready),  128'(0));
      chk("rst_out_sum",   128'(u_if.out_sum),   128'(0));
      chk("rst_out_count", 128'(u_if.out_count), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // AW=64, LEN=2 instance: two all-ones products wrap and flag overflow
      u_if64.in_valid = 1; u_if64.in_prod = ONES;
      repeat (2) @(negedge clk);
      u_if64.in_valid = 0;
      chk("w64_out_valid", 128'(u_if64.out_valid), 128'(1));
      chk("w64_out_sum",   128'(u_if64.out_sum),   128'(64'hFFFF_FFFF_FFFF_FFFE));
      chk("w64_out_count", 128'(u_if64.out_count), 128'(2));
      chk("w64_out_ovf",   128'(u_if64.out_ovf),   128'(1));
      u_if64.out_ready = 1;
      @(negedge clk);
      u_if64.out_ready = 0;
      chk("w64_valid_drop", 128'(u_if64.out_valid), 128'(0));
      chk("w64_ovf_clear",  128'(u_if64.out_ovf),   128'(0));
      chk("w64_in_ready",   128'(u_if64.in_ready),  128'(1));

      // Full vector of ones
      for (int i = 0; i < 8; i++) send(64'd1, 1'b0);
      check_res("t1", 72'd8, 8'd8, 1'b0);

      // Early termination with in_last
      send(64'd3, 1'b0); send(64'd5, 1'b0); send(64'd7, 1'b1);
      check_res("t2", 72'd15, 8'd3, 1'b0);

      // in_last on the first product
      send(64'd42, 1'b1);
      check_res("first_last", 72'd42, 8'd1, 1'b0);

      // in_last coinciding with the LEN-th product
      for (int i = 0; i < 7; i++) send(64'd2, 1'b0);
      send(64'd2, 1'b1);
      check_res("len_last", 72'd16, 8'd8, 1'b0);

      // Backpressure: result held, next product waits for the out handshake
      u_if.out_ready = 0;
      send(64'd4, 1'b0); send(64'd6, 1'b1);
      u_if.in_valid = 1; u_if.in_prod = 64'd100; u_if.in_last = 1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", 128'(u_if.in_ready),  128'(0));
         chk("bp_out_sum",  128'(u_if.out_sum),   128'(10));
         @(negedge clk);
      end
      u_if.out_ready = 1;
      send(64'd100, 1'b1);
      check_res("bp_held", 72'd10, 8'd2, 1'b0);
      check_res("bp_next", 72'd100, 8'd1, 1'b0);

      // Wide sum of all-ones products, no carry out of 72 bits
      for (int i = 0; i < 8; i++) send(ONES, 1'b0);
      check_res("wide", 72'h7_FFFF_FFFF_FFFF_FFF8, 8'd8, 1'b0);

      // clear mid-vector, with a product offered in the clear cycle
      for (int i = 0; i < 4; i++) send(64'd10, 1'b0);
      clear = 1; u_if.in_valid = 1; u_if.in_prod = 64'd10;
      @(negedge clk);
      clear = 0; u_if.in_valid = 0;
      for (int i = 0; i < 8; i++) send(64'd1, 1'b0);
      check_res("t5", 72'd8, 8'd8, 1'b0);

      // Asynchronous reset mid-vector
      send(64'd5, 1'b0); send(64'd5, 1'b0); send(64'd5, 1'b0);
      #1 rst_n = 0;
      #1;
      chk("arst_vec_in_ready", 128'(u_if.in_ready), 128'(0));
      chk("arst_vec_out_sum",  128'(u_if.out_sum),  128'(0));
      chk("arst_vec_ovf",      128'(u_if.out_ovf),  128'(0));
      @(negedge clk);
      rst_n = 1;

      // Asynchronous reset while a result is pending
      u_if.out_ready = 0;
      send(64'd9, 1'b1);
      chk("pre_arst_valid", 128'(u_if.out_valid), 128'(1));
      #1 rst_n = 0;
      #1;
      chk("arst_done_valid", 128'(u_if.out_valid), 128'(0));
      chk("arst_done_sum",   128'(u_if.out_sum),   128'(0));
      chk("arst_done_count", 128'(u_if.out_count), 128'(0));
      @(negedge clk);
      rst_n = 1;
      u_if.out_ready = 1;

      // Integration: product of A=B=0x0001_0000
      a = 32'h0001_0000; b = 32'h0001_0000;
      p = 64'(a) * 64'(b);
      send(p, 1'b1);
      check_res("integ", 72'h1_0000_0000, 8'd1, 1'b0);

      repeat (4) @(negedge clk);
      chk("leftover_results", 128'(rq.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, required completion");
      $fatal(1);
   end
endmodule
